// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Brief    : Instruction-bus field positions, idle word and sequencer states
//            shared by core_inst_gen and its sub-modules.
// Revision : 1.0  initial release
// ============================================================================
package core_pkg;

    localparam int C_INST_W    = 35;

    localparam int C_KLOAD     = 0;
    localparam int C_EXEC      = 1;
    localparam int C_L0_WR     = 2;
    localparam int C_L0_RD     = 3;
    localparam int C_OFIFO_RD  = 6;
    localparam int C_XA_LSB    = 7;
    localparam int C_XA_MSB    = 17;
    localparam int C_XWEN_N    = 18;
    localparam int C_XCEN_N    = 19;
    localparam int C_PA_LSB    = 20;
    localparam int C_PA_MSB    = 30;
    localparam int C_PWEN_N    = 31;
    localparam int C_PCEN_N    = 32;
    localparam int C_ACC       = 33;
    localparam int C_RELU      = 34;

    // Both SRAMs deselected with write disabled; every other field zero.
    localparam logic [C_INST_W-1:0] C_IDLE_WORD = 35'h1_800C_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WFETCH = 3'd1,
        S_KLOAD  = 3'd2,
        S_XFETCH = 3'd3,
        S_EXEC   = 3'd4,
        S_DRAIN  = 3'd5,
        S_SFP    = 3'd6,
        S_DONE   = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/core_inst_gen_cnt.sv
`default_nettype none
// ============================================================================
// Module   : core_inst_gen_cnt
// Brief    : Phase counter, clearable to zero, with terminal-count flag.
// Revision : 1.0  initial release
// ============================================================================
module core_inst_gen_cnt #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;
    assign tc    = (r_count == last);

endmodule
`default_nettype wire

// File: rtl/core_inst_gen.sv
`default_nettype none
// ============================================================================
// Module   : core_inst_gen
// Brief    : Start-pulse sequencer driving the 35-bit core instruction bus.
//            Define INST_GEN_TIMEOUT_EN to enable the DRAIN watchdog.
// Revision : 1.0  initial release
// ============================================================================
module core_inst_gen
    import core_pkg::*;
#(
    parameter int ROW    = 8,
    parameter int COL    = 8,
    parameter int ADDR_W = 11,
    parameter int TO_W   = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   cfg_w_base,
    input  logic [ADDR_W-1:0]   cfg_x_base,
    input  logic [ADDR_W-1:0]   cfg_x_len,
    input  logic [ADDR_W-1:0]   cfg_p_base,
    input  logic                cfg_sfp,
    input  logic                cfg_relu,
    input  logic                ofifo_valid,
    output logic [C_INST_W-1:0] inst,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int C_KLOAD_LAST = 2 * COL + ROW - 1;
    localparam int C_CNT_W = ($clog2(C_KLOAD_LAST + 1) > ADDR_W) ? $clog2(C_KLOAD_LAST + 1) : ADDR_W;

    state_t                r_state, w_next;
    logic [ADDR_W-1:0]     r_w_base, r_x_base, r_x_len, r_p_base;
    logic                  r_sfp, r_relu;
    logic [C_CNT_W-1:0]    w_cnt, w_cnt_last, w_len, w_len_m1;
    logic                  w_cnt_clr, w_cnt_en, w_tc;
    logic [ADDR_W-1:0]     w_cnt_a;
    logic [ADDR_W-1:0]     r_rd_cnt;
    logic                  r_wr_pend, w_rd;
    logic [C_INST_W-1:0]   w_inst, r_inst;
    logic                  w_done, r_done, r_busy;
    logic                  w_start_ok;
`ifdef INST_GEN_TIMEOUT_EN
    logic [TO_W-1:0]       r_to;
    logic                  r_err, w_to_hit;
`endif

    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_len      = C_CNT_W'(r_x_len);
    assign w_len_m1   = w_len - C_CNT_W'(1);
    assign w_cnt_a    = w_cnt[ADDR_W-1:0];

    core_inst_gen_cnt #(.WIDTH(C_CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_cnt_clr),
        .en    (w_cnt_en),
        .last  (w_cnt_last),
        .count (w_cnt),
        .tc    (w_tc)
    );

    always_comb begin
        w_next     = r_state;
        w_cnt_en   = 1'b1;
        w_cnt_last = '0;
        w_inst     = C_IDLE_WORD;
        w_done     = 1'b0;
        w_rd       = 1'b0;
`ifdef INST_GEN_TIMEOUT_EN
        w_to_hit   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_en = 1'b0;
                if (start) w_next = S_WFETCH;
            end
            S_WFETCH: begin
                // One extra cycle lets the last SRAM read land in L0.
                w_cnt_last = C_CNT_W'(COL);
                if (!w_tc) begin
                    w_inst[C_XCEN_N]           = 1'b0;
                    w_inst[C_XA_MSB:C_XA_LSB]  = r_w_base + w_cnt_a;
                end
                if (w_cnt != '0) w_inst[C_L0_WR] = 1'b1;
                if (w_tc) w_next = S_KLOAD;
            end
            S_KLOAD: begin
                w_cnt_last = C_CNT_W'(C_KLOAD_LAST);
                if (w_cnt < C_CNT_W'(COL)) begin
                    w_inst[C_KLOAD] = 1'b1;
                    w_inst[C_L0_RD] = 1'b1;
                end
                if (w_tc) w_next = (r_x_len == '0) ? S_DONE : S_XFETCH;
            end
            S_XFETCH: begin
                w_cnt_last = w_len;
                if (!w_tc) begin
                    w_inst[C_XCEN_N]           = 1'b0;
                    w_inst[C_XA_MSB:C_XA_LSB]  = r_x_base + w_cnt_a;
                end
                if (w_cnt != '0) w_inst[C_L0_WR] = 1'b1;
                if (w_tc) w_next = S_EXEC;
            end
            S_EXEC: begin
                w_cnt_last      = w_len_m1;
                w_inst[C_EXEC]  = 1'b1;
                w_inst[C_L0_RD] = 1'b1;
                if (w_tc) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                // Counter tracks PMEM writes; each read produces one write a cycle later.
                w_cnt_last          = w_len_m1;
                w_cnt_en            = r_wr_pend;
                w_rd                = ofifo_valid && (r_rd_cnt != r_x_len);
                w_inst[C_OFIFO_RD]  = w_rd;
                if (r_wr_pend) begin
                    w_inst[C_PCEN_N]           = 1'b0;
                    w_inst[C_PWEN_N]           = 1'b0;
                    w_inst[C_PA_MSB:C_PA_LSB]  = r_p_base + w_cnt_a;
                    if (w_tc) w_next = r_sfp ? S_SFP : S_DONE;
                end
`ifdef INST_GEN_TIMEOUT_EN
                if ((w_next == S_DRAIN) && !ofifo_valid && (r_to == '1)) begin
                    w_to_hit = 1'b1;
                    w_next   = S_DONE;
                end
`endif
            end
            S_SFP: begin
                w_cnt_last                 = w_len_m1;
                w_inst[C_PCEN_N]           = 1'b0;
                w_inst[C_PA_MSB:C_PA_LSB]  = r_p_base + w_cnt_a;
                w_inst[C_ACC]              = 1'b1;
                w_inst[C_RELU]             = r_relu;
                if (w_tc) w_next = S_DONE;
            end
            S_DONE: begin
                w_cnt_en = 1'b0;
                w_done   = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        w_cnt_clr = (w_next != r_state);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_inst    <= C_IDLE_WORD;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_rd_cnt  <= '0;
            r_wr_pend <= 1'b0;
            r_w_base  <= '0;
            r_x_base  <= '0;
            r_x_len   <= '0;
            r_p_base  <= '0;
            r_sfp     <= 1'b0;
            r_relu    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_inst    <= w_inst;
            r_done    <= w_done;
            r_busy    <= (r_state != S_IDLE);
            r_wr_pend <= w_rd;
            if (r_state != S_DRAIN) begin
                r_rd_cnt <= '0;
            end else if (w_rd) begin
                r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
            end
            if (w_start_ok) begin
                r_w_base <= cfg_w_base;
                r_x_base <= cfg_x_base;
                r_x_len  <= cfg_x_len;
                r_p_base <= cfg_p_base;
                r_sfp    <= cfg_sfp;
                r_relu   <= cfg_relu;
            end
        end
    end

`ifdef INST_GEN_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to  <= '0;
            r_err <= 1'b0;
        end else begin
            if ((r_state != S_DRAIN) || ofifo_valid) begin
                r_to <= '0;
            end else begin
                r_to <= r_to + TO_W'(1);
            end
            if (w_start_ok) begin
                r_err <= 1'b0;
            end else if (w_to_hit) begin
                r_err <= 1'b1;
            end
        end
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign inst = r_inst;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_core_inst_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_inst_gen
// Brief    : Scoreboard bench for core_inst_gen: expected SRAM accesses and
//            done timing are queued by stimulus, popped by a monitor.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_core_inst_gen;

    localparam int ROW = 8, COL = 8, ADDR_W = 11, TO_W = 4;
    localparam logic [34:0] IDLE = 35'h1_800C_0000;

    logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [ADDR_W-1:0] cfg_w_base = '0, cfg_x_base = '0, cfg_x_len = '0, cfg_p_base = '0;
    logic              cfg_sfp = 1'b0, cfg_relu = 1'b0, ofifo_valid = 1'b0;
    logic [34:0]       inst;
    logic              busy, done, err;

    int n_checks = 0, n_errors = 0;
    int cyc = 0, t0 = 0, vmode = 2, done_seen = 0;
    int n_kload = 0, n_exec = 0, n_l0wr = 0, n_l0rd = 0, n_ofrd = 0;
    logic rsvd_bad = 1'b0;
    logic [11:0] xq[$];
    logic [13:0] pq[$];
    int dq[$];

    core_inst_gen #(.ROW(ROW), .COL(COL), .ADDR_W(ADDR_W), .TO_W(TO_W)) dut (
        .clk(clk), .reset(rst_n), .start(start),
        .cfg_w_base(cfg_w_base), .cfg_x_base(cfg_x_base), .cfg_x_len(cfg_x_len),
        .cfg_p_base(cfg_p_base), .cfg_sfp(cfg_sfp), .cfg_relu(cfg_relu),
        .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        case (vmode)
            0:       ofifo_valid = 1'b1;
            1:       ofifo_valid = ~ofifo_valid;
            default: ofifo_valid = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an SRAM access or done.
    always @(negedge clk) begin
        int e;
        if (!inst[19]) begin
            if (xq.size() == 0) check("xmem_unexpected", 1, 0);
            else check("xmem_access", {inst[18], inst[17:7]}, xq.pop_front());
        end
        if (!inst[32]) begin
            if (pq.size() == 0) check("pmem_unexpected", 1, 0);
            else check("pmem_access", {inst[31], inst[33], inst[34], inst[30:20]}, pq.pop_front());
        end
        if (!inst[18] && !inst[31]) check("dual_write", 1, 0);
        if (done) begin
            done_seen++;
            if (dq.size() == 0) check("done_unexpected", 1, 0);
            else begin
                e = dq.pop_front();
                if (e >= 0) check("done_cycle", cyc - t0, e);
            end
        end
        n_kload += int'(inst[0]);
        n_exec  += int'(inst[1]);
        n_l0wr  += int'(inst[2]);
        n_l0rd  += int'(inst[3]);
        n_ofrd  += int'(inst[6]);
        if (inst[5:4] != 2'b00) rsvd_bad = 1'b1;
    end

    task automatic start_job(input logic [10:0] wb, xb, xl, pb, input logic sfp, relu,
                             input int vm, input int exp_done, input bit push_pmem, input bit extra_start);
        for (int i = 0; i < COL; i++) xq.push_back({1'b1, 11'(wb + i)});
        for (int i = 0; i < int'(xl); i++) xq.push_back({1'b1, 11'(xb + i)});
        if (push_pmem) begin
            for (int k = 0; k < int'(xl); k++) pq.push_back({3'b000, 11'(pb + k)});
            if (sfp) for (int i = 0; i < int'(xl); i++) pq.push_back({2'b11, relu, 11'(pb + i)});
        end
        if (exp_done != -2) dq.push_back(exp_done);
        n_kload = 0; n_exec = 0; n_l0wr = 0; n_l0rd = 0; n_ofrd = 0; done_seen = 0;
        rsvd_bad = 1'b0;
        vmode = vm;
        @(negedge clk);
        cfg_w_base = wb; cfg_x_base = xb; cfg_x_len = xl; cfg_p_base = pb;
        cfg_sfp = sfp; cfg_relu = relu; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        // Later cfg changes must not affect the running job.
        cfg_w_base = ~wb; cfg_x_base = ~xb; cfg_x_len = xl + 11'd5; cfg_p_base = ~pb;
        cfg_sfp = ~sfp; cfg_relu = ~relu;
        if (extra_start) begin
            repeat (5) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic finish_job(input int xl, input logic exp_err, input int exp_ofifo);
        int n = 0;
        while (done_seen == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("job_completes", done_seen != 0, 1);
        repeat (2) @(negedge clk);
        check("busy_after_done", busy, 0);
        check("inst_idle_after_done", inst, IDLE);
        check("err_flag", err, exp_err);
        check("kload_cycles", n_kload, COL);
        check("exec_cycles", n_exec, xl);
        check("l0_wr_cycles", n_l0wr, COL + xl);
        check("l0_rd_cycles", n_l0rd, COL + xl);
        check("ofifo_rd_cycles", n_ofrd, exp_ofifo);
        check("xmem_queue_left", xq.size(), 0);
        check("pmem_queue_left", pq.size(), 0);
        check("reserved_bits", rsvd_bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_inst", inst, IDLE);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_inst", inst, IDLE);
        check("idle_busy", busy, 0);

        // A: basic job, valid stuck high, cfg scrambled and start re-pulsed mid-job
        start_job(11'h010, 11'h100, 11'd4, 11'h020, 1'b0, 1'b0, 0, 48, 1'b1, 1'b1);
        finish_job(4, 1'b0, 4);

        // B: zero activations -> straight to DONE after kernel settle
        start_job(11'h7F0, 11'h055, 11'd0, 11'h066, 1'b1, 1'b1, 0, 34, 1'b1, 1'b0);
        finish_job(0, 1'b0, 0);

        // C: address wrap on both SRAMs, SFP with ReLU, valid toggling
        start_job(11'd2044, 11'd2047, 11'd3, 11'd2046, 1'b1, 1'b1, 1, -1, 1'b1, 1'b0);
        finish_job(3, 1'b0, 3);

        // E: ofifo_valid held low in DRAIN
`ifdef INST_GEN_TIMEOUT_EN
        start_job(11'h008, 11'h030, 11'd2, 11'h040, 1'b0, 1'b0, 2, 55, 1'b0, 1'b0);
        finish_job(2, 1'b1, 0);
`else
        start_job(11'h008, 11'h030, 11'd2, 11'h040, 1'b0, 1'b0, 2, -1, 1'b1, 1'b0);
        repeat (80) @(negedge clk);
        check("drain_waits_no_done", done_seen, 0);
        check("drain_waits_busy", busy, 1);
        check("drain_waits_err", err, 0);
        vmode = 0;
        finish_job(2, 1'b0, 2);
`endif

        // F: single activation with SFP, no ReLU; err must be clear after start
        start_job(11'h000, 11'h010, 11'd1, 11'h005, 1'b1, 1'b0, 0, 40, 1'b1, 1'b0);
        finish_job(1, 1'b0, 1);

        // D: reset in the middle of EXEC aborts with no done pulse
        start_job(11'h040, 11'h200, 11'd4, 11'h300, 1'b0, 1'b0, 0, -2, 1'b1, 1'b0);
        n = 0;
        while (n_exec < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reached_exec", n_exec >= 2, 1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_inst", inst, IDLE);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        pq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_done", done_seen, 0);
        check("abort_stays_idle", busy, 0);
        check("abort_xmem_left", xq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
